// File: rtl/bus_ctrl_pkg.sv
// Shared constants for the common-bus timing-and-control unit:
// top-level states, bus source codes, strobe indices and opcodes.
package bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_AR   = 3'd1;
    localparam logic [2:0] SEL_PC   = 3'd2;
    localparam logic [2:0] SEL_DR   = 3'd3;
    localparam logic [2:0] SEL_AC   = 3'd4;
    localparam logic [2:0] SEL_IR   = 3'd5;
    localparam logic [2:0] SEL_TR   = 3'd6;
    localparam logic [2:0] SEL_MEM  = 3'd7;

    localparam int LD_AR = 0;
    localparam int LD_PC = 1;
    localparam int LD_DR = 2;
    localparam int LD_AC = 3;
    localparam int LD_IR = 4;
    localparam int LD_TR = 5;

    // INR and CLR share this indexing
    localparam int R_AR = 0;
    localparam int R_PC = 1;
    localparam int R_DR = 2;
    localparam int R_AC = 3;
    localparam int R_TR = 4;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    localparam int RR_CLA = 11;
    localparam int RR_INC = 5;
    localparam int RR_HLT = 0;

endpackage

// File: rtl/seq_counter.sv
// 4-bit sequence counter with synchronous clear and count enable,
// plus a one-hot decode of the current timing step.
module seq_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [3:0]  cnt_o,
    output logic [15:0] t_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign t_o   = 16'h0001 << cnt_q;

endmodule

// File: rtl/bus_sequencer.sv
// Fetch/decode/execute control for the common-bus datapath:
// one register transfer per clock, decoded from state, SC and opcode.
module bus_sequencer
    import bus_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic        dr_zero,
    output logic [2:0]  select,
    output logic [5:0]  LD,
    output logic [4:0]  INR,
    output logic [4:0]  CLR,
    output logic        read,
    output logic        write,
    output logic        enable,
    output logic [3:0]  sc,
    output logic        running,
    output logic        instr_done,
    output logic        illegal
);

    state_e     state_q, state_d;
    logic [2:0] opc_q, opc_d;
    logic       i_q, i_d;
    logic       ill_q, ill_d;
    logic [15:0] t;
    logic       run;
    logic       go;
    logic       halt;
    logic       set_ill;
    logic       sc_clr;
    logic       unused_ok;

    assign run = (state_q == ST_RUN);
    assign go  = !run && start;

    // Out-of-range SC values fall through the decode and get cleared here
    assign sc_clr = !run || instr_done || (sc > 4'd6);

    seq_counter u_sc (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .clr_i  (sc_clr),
        .en_i   (run),
        .cnt_o  (sc),
        .t_o    (t)
    );

    always_comb begin
        select     = SEL_NONE;
        LD         = '0;
        INR        = '0;
        CLR        = '0;
        read       = 1'b0;
        write      = 1'b0;
        instr_done = 1'b0;
        halt       = 1'b0;
        set_ill    = 1'b0;
        if (run) begin
            unique case (1'b1)
                t[0]: begin
                    select    = SEL_PC;
                    LD[LD_AR] = 1'b1;
                end
                t[1]: begin
                    select     = SEL_MEM;
                    read       = 1'b1;
                    LD[LD_IR]  = 1'b1;
                    INR[R_PC]  = 1'b1;
                end
                t[2]: begin
                    select    = SEL_IR;
                    LD[LD_AR] = 1'b1;
                end
                t[3]: begin
                    if (opc_q == OP_REG) begin
                        instr_done = 1'b1;
                        if (!i_q) begin
                            if (ir[RR_CLA]) begin
                                CLR[R_AC] = 1'b1;
                            end else if (ir[RR_INC]) begin
                                INR[R_AC] = 1'b1;
                            end
                            halt = ir[RR_HLT];
                        end
                    end else if (i_q) begin
                        select    = SEL_MEM;
                        read      = 1'b1;
                        LD[LD_AR] = 1'b1;
                    end
                end
                t[4]: begin
                    case (opc_q)
                        OP_LDA, OP_ISZ: begin
                            select    = SEL_MEM;
                            read      = 1'b1;
                            LD[LD_DR] = 1'b1;
                        end
                        OP_STA: begin
                            select     = SEL_AC;
                            write      = 1'b1;
                            instr_done = 1'b1;
                        end
                        OP_BUN: begin
                            select     = SEL_AR;
                            LD[LD_PC]  = 1'b1;
                            instr_done = 1'b1;
                        end
                        OP_BSA: begin
                            select    = SEL_PC;
                            write     = 1'b1;
                            INR[R_AR] = 1'b1;
                        end
                        OP_AND, OP_ADD: begin
                            set_ill    = 1'b1;
                            instr_done = 1'b1;
                        end
                        default: instr_done = 1'b1;
                    endcase
                end
                t[5]: begin
                    case (opc_q)
                        OP_LDA: begin
                            select     = SEL_DR;
                            LD[LD_AC]  = 1'b1;
                            instr_done = 1'b1;
                        end
                        OP_BSA: begin
                            select     = SEL_AR;
                            LD[LD_PC]  = 1'b1;
                            instr_done = 1'b1;
                        end
                        OP_ISZ:  INR[R_DR] = 1'b1;
                        default: instr_done = 1'b1;
                    endcase
                end
                t[6]: begin
                    instr_done = 1'b1;
                    if (opc_q == OP_ISZ) begin
                        select    = SEL_DR;
                        write     = 1'b1;
                        INR[R_PC] = dr_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign enable  = (select != SEL_NONE);
    assign running = run;
    assign illegal = ill_q;

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        i_d     = i_q;
        ill_d   = ill_q;
        if (go) begin
            state_d = ST_RUN;
            ill_d   = 1'b0;
        end
        if (run && halt) begin
            state_d = ST_HALT;
        end
        if (run && set_ill) begin
            ill_d = 1'b1;
        end
        if (run && t[2]) begin
            opc_d = ir[14:12];
            i_d   = ir[15];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            opc_q   <= OP_AND;
            i_q     <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            i_q     <= i_d;
            ill_q   <= ill_d;
        end
    end

    assign unused_ok = ^{ir[10:6], ir[4:1], t[15:7]};

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: per-step control words are
// predicted from the instruction table and compared every cycle.
module tb_bus_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ir = 16'h0000;
    logic        dr_zero = 1'b0;
    logic [2:0]  select;
    logic [5:0]  LD;
    logic [4:0]  INR;
    logic [4:0]  CLR;
    logic        read;
    logic        write;
    logic        enable;
    logic [3:0]  sc;
    logic        running;
    logic        instr_done;
    logic        illegal;

    typedef struct packed {
        logic [2:0] sel;
        logic [5:0] ld;
        logic [4:0] inr;
        logic [4:0] clr;
        logic       rd;
        logic       wr;
        logic       done;
    } step_t;

    step_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    logic  ill_exp = 1'b0;
    logic  halted = 1'b1;

    bus_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .ir         (ir),
        .dr_zero    (dr_zero),
        .select     (select),
        .LD         (LD),
        .INR        (INR),
        .CLR        (CLR),
        .read       (read),
        .write      (write),
        .enable     (enable),
        .sc         (sc),
        .running    (running),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    function automatic step_t mk(input logic [2:0] s, input logic [5:0] l,
                                 input logic [4:0] n, input logic [4:0] c,
                                 input logic r, input logic w,
                                 input logic d);
        step_t x;
        x.sel = s; x.ld = l; x.inr = n; x.clr = c;
        x.rd = r; x.wr = w; x.done = d;
        return x;
    endfunction

    // Expected control word for every step of one instruction
    task automatic build(input logic [15:0] w, input logic drz,
                         output logic hlt);
        logic [2:0] op;
        logic       ind;
        logic [4:0] c;
        logic [4:0] n;
        op  = w[14:12];
        ind = w[15];
        hlt = 1'b0;
        exp_q.delete();
        exp_q.push_back(mk(3'd2, 6'b000001, 5'b0, 5'b0, 0, 0, 0));
        exp_q.push_back(mk(3'd7, 6'b010000, 5'b00010, 5'b0, 1, 0, 0));
        exp_q.push_back(mk(3'd5, 6'b000001, 5'b0, 5'b0, 0, 0, 0));
        if (op == 3'd7) begin
            c = (!ind && w[11]) ? 5'b01000 : 5'b0;
            n = (!ind && w[5] && !w[11]) ? 5'b01000 : 5'b0;
            hlt = !ind && w[0];
            exp_q.push_back(mk(3'd0, 6'b0, n, c, 0, 0, 1));
            return;
        end
        if (ind) exp_q.push_back(mk(3'd7, 6'b000001, 5'b0, 5'b0, 1, 0, 0));
        else     exp_q.push_back(mk(3'd0, 6'b0, 5'b0, 5'b0, 0, 0, 0));
        case (op)
            3'd2: begin
                exp_q.push_back(mk(3'd7, 6'b000100, 5'b0, 5'b0, 1, 0, 0));
                exp_q.push_back(mk(3'd3, 6'b001000, 5'b0, 5'b0, 0, 0, 1));
            end
            3'd3: exp_q.push_back(mk(3'd4, 6'b0, 5'b0, 5'b0, 0, 1, 1));
            3'd4: exp_q.push_back(mk(3'd1, 6'b000010, 5'b0, 5'b0, 0, 0, 1));
            3'd5: begin
                exp_q.push_back(mk(3'd2, 6'b0, 5'b00001, 5'b0, 0, 1, 0));
                exp_q.push_back(mk(3'd1, 6'b000010, 5'b0, 5'b0, 0, 0, 1));
            end
            3'd6: begin
                exp_q.push_back(mk(3'd7, 6'b000100, 5'b0, 5'b0, 1, 0, 0));
                exp_q.push_back(mk(3'd0, 6'b0, 5'b00100, 5'b0, 0, 0, 0));
                n = drz ? 5'b00010 : 5'b0;
                exp_q.push_back(mk(3'd3, 6'b0, n, 5'b0, 0, 1, 1));
            end
            default: exp_q.push_back(mk(3'd0, 6'b0, 5'b0, 5'b0, 0, 0, 1));
        endcase
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        ill_exp = 1'b0;
        halted = 1'b0;
    endtask

    task automatic run_instr(input logic [15:0] w, input logic drz,
                             input logic hold_start, input string nm);
        logic  hlt;
        step_t got;
        ir = w;
        dr_zero = drz;
        start = hold_start;
        build(w, drz, hlt);
        for (int k = 0; k < exp_q.size(); k++) begin
            got = {select, LD, INR, CLR, read, write, instr_done};
            tests++;
            if (got !== exp_q[k] || sc !== 4'(k) || running !== 1'b1 ||
                enable !== (select != 3'd0)) begin
                fails++;
                $display("FAIL %s step T%0d: got %h sc=%0d run=%b en=%b, want %h sc=%0d",
                         nm, k, got, sc, running, enable, exp_q[k], k);
            end
            @(posedge clock);
            @(negedge clock);
        end
        start = 1'b0;
        if (w[14:12] < 3'd2) ill_exp = 1'b1;
        tests++;
        if (hlt) begin
            halted = 1'b1;
            if ({select, LD, INR, CLR, read, write, enable, instr_done,
                 running, sc} !== '0) begin
                fails++;
                $display("FAIL %s halt: run=%b sc=%0d sel=%0d, want all 0",
                         nm, running, sc, select);
            end
        end else if (running !== 1'b1 || sc !== 4'd0) begin
            fails++;
            $display("FAIL %s end: run=%b sc=%0d, want run=1 sc=0",
                     nm, running, sc);
        end
        tests++;
        if (illegal !== ill_exp) begin
            fails++;
            $display("FAIL %s illegal: got %b want %b", nm, illegal, ill_exp);
        end
    endtask

    task automatic check_idle(input string nm);
        tests++;
        if ({select, LD, INR, CLR, read, write, enable, instr_done,
             running, sc, illegal} !== '0) begin
            fails++;
            $display("FAIL %s: run=%b sc=%0d sel=%0d ld=%b ill=%b, want all 0",
                     nm, running, sc, select, LD, illegal);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        check_idle("reset");
        reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_idle("idle_no_start");
    endtask

    task automatic test_lda();
        do_start();
        run_instr(16'h2010, 1'b0, 1'b0, "lda");
    endtask

    task automatic test_sta_indirect();
        run_instr(16'hB020, 1'b0, 1'b0, "sta_ind");
    endtask

    task automatic test_isz();
        run_instr(16'h6030, 1'b1, 1'b0, "isz_z1");
        run_instr(16'h6030, 1'b0, 1'b0, "isz_z0");
    endtask

    task automatic test_cla_inc();
        run_instr(16'h7820, 1'b0, 1'b0, "cla_inc");
    endtask

    task automatic test_start_in_run();
        run_instr(16'h5123, 1'b0, 1'b1, "bsa_start_held");
    endtask

    task automatic test_illegal();
        run_instr(16'h0000, 1'b0, 1'b0, "and_illegal");
        run_instr(16'h1ABC, 1'b1, 1'b0, "add_illegal");
    endtask

    task automatic test_hlt();
        run_instr(16'h7001, 1'b0, 1'b0, "hlt");
        @(posedge clock);
        @(negedge clock);
        tests++;
        if (running !== 1'b0 || illegal !== ill_exp) begin
            fails++;
            $display("FAIL hlt_stays: run=%b ill=%b, want run=0 ill=%b",
                     running, illegal, ill_exp);
        end
        do_start();
        run_instr(16'h4055, 1'b0, 1'b0, "bun_after_hlt");
        run_instr(16'h7001, 1'b0, 1'b1, "hlt_with_start");
        do_start();
        run_instr(16'h3044, 1'b0, 1'b0, "sta_after_hlt");
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int i = 0; i < 40; i++) begin
            if (halted) do_start();
            w = 16'($urandom);
            run_instr(w, 1'($urandom), ($urandom_range(0, 3) == 0), "random");
        end
    endtask

    task automatic test_async_reset();
        if (halted) do_start();
        ir = 16'h6030;
        dr_zero = 1'b1;
        repeat (5) begin
            @(posedge clock);
            @(negedge clock);
        end
        tests++;
        if (sc !== 4'd5 || INR !== 5'b00100) begin
            fails++;
            $display("FAIL areset_pre: sc=%0d inr=%b, want sc=5 inr=00100",
                     sc, INR);
        end
        #2 reset_n = 1'b0;
        #1 check_idle("areset_async");
        @(posedge clock);
        @(negedge clock);
        check_idle("areset_held");
        reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_idle("areset_release");
        ill_exp = 1'b0;
        halted = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lda();
        test_sta_indirect();
        test_isz();
        test_cla_inc();
        test_start_in_run();
        test_illegal();
        test_hlt();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
